// File: rtl/spart_pkg.sv
// Shared definitions for the SPART host driver: bus addresses, FSM states and
// the elaboration-time baud divisor table.
package spart_pkg;

    localparam logic [1:0] ADDR_BUF    = 2'b00;
    localparam logic [1:0] ADDR_STATUS = 2'b01;
    localparam logic [1:0] ADDR_DB_LO  = 2'b10;
    localparam logic [1:0] ADDR_DB_HI  = 2'b11;

    typedef enum logic [2:0] {
        CFG_LO = 3'd0,
        CFG_HI = 3'd1,
        IDLE   = 3'd2,
        RX_RD  = 3'd3,
        TX_WR  = 3'd4,
        GAP    = 3'd5
    } state_t;

    localparam int BAUD_TABLE [4] = '{9600, 19200, 38400, 76800};

    // Only ever called with constants, so the division folds away at elaboration.
    function automatic logic [15:0] divisor(input int clk_hz, input logic [1:0] sel);
        logic [31:0] q;
        q = 32'(clk_hz / BAUD_TABLE[sel]);
        return q[15:0];
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with combinational head read; pointers wrap modulo DEPTH.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push, do_pop;

    always_comb begin
        do_push  = push & ~full;
        do_pop   = pop & ~empty;
        wr_ptr_d = wr_ptr_q + AW'(do_push);
        rd_ptr_d = rd_ptr_q + AW'(do_pop);
        count_d  = count_q + CW'(do_push) - CW'(do_pop);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: the pointers alone decide what is valid.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wdata;
        end
    end

    assign rdata = mem_q[rd_ptr_q];
    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == '0);
    assign count = count_q;

endmodule

// File: rtl/spart_echo_driver.sv
// SPART host driver: programs the baud divisor after reset, then echoes every
// received byte back to the transmitter through a small FIFO.
module spart_echo_driver
    import spart_pkg::*;
#(
    parameter int CLK_FREQ_HZ = 50_000_000,
    parameter int FIFO_DEPTH  = 8
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [1:0]                  br_cfg,
    input  logic                        rda,
    input  logic                        tbr,
    output logic                        iocs,
    output logic                        iorw,
    output logic [1:0]                  ioaddr,
    inout  wire  [7:0]                  databus,
    output logic                        cfg_done,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count,
    output state_t                      dbg_state
);

    // Bus handshake: one access per cycle in which iocs is high, direction from
    // iorw (1=read); a read captures databus at the closing edge, a write drives
    // databus only for that cycle; every access is followed by an iocs-low GAP.

    localparam logic [15:0] DIV_TBL [4] = '{
        divisor(CLK_FREQ_HZ, 2'd0),
        divisor(CLK_FREQ_HZ, 2'd1),
        divisor(CLK_FREQ_HZ, 2'd2),
        divisor(CLK_FREQ_HZ, 2'd3)
    };

    state_t     state_q, state_d;
    logic [1:0] cfg_q, cfg_d;
    logic       cfg_done_q, cfg_done_d;
    logic       last_rx_q, last_rx_d;

    logic       fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [7:0] fifo_rdata;
    logic       rx_ok, tx_ok;
    logic [7:0] wdata;

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .wdata (databus),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign rx_ok = rda & ~fifo_full;
    assign tx_ok = tbr & ~fifo_empty;

    always_comb begin
        state_d    = state_q;
        cfg_d      = cfg_q;
        cfg_done_d = cfg_done_q;
        last_rx_d  = last_rx_q;
        fifo_push  = 1'b0;
        fifo_pop   = 1'b0;
        unique case (state_q)
            CFG_LO: begin
                cfg_d   = br_cfg;
                state_d = CFG_HI;
            end
            CFG_HI: state_d = GAP;
            GAP: begin
                cfg_done_d = 1'b1;
                state_d    = IDLE;
            end
            IDLE: begin
                if (br_cfg != cfg_q) begin
                    cfg_done_d = 1'b0;
                    state_d    = CFG_LO;
                end else if (rx_ok && tx_ok) begin
                    state_d = last_rx_q ? TX_WR : RX_RD;
                end else if (rx_ok) begin
                    state_d = RX_RD;
                end else if (tx_ok) begin
                    state_d = TX_WR;
                end
            end
            RX_RD: begin
                fifo_push = 1'b1;
                last_rx_d = 1'b1;
                state_d   = GAP;
            end
            TX_WR: begin
                fifo_pop  = 1'b1;
                last_rx_d = 1'b0;
                state_d   = GAP;
            end
            default: state_d = CFG_LO;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= CFG_LO;
            cfg_q      <= 2'b00;
            cfg_done_q <= 1'b0;
            last_rx_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cfg_q      <= cfg_d;
            cfg_done_q <= cfg_done_d;
            last_rx_q  <= last_rx_d;
        end
    end

    // Bus outputs decode the state; holding reset forces the idle bus at once.
    always_comb begin
        iocs   = 1'b0;
        iorw   = 1'b1;
        ioaddr = ADDR_BUF;
        wdata  = 8'h00;
        if (rst) begin
            unique case (state_q)
                CFG_LO: begin
                    iocs   = 1'b1;
                    iorw   = 1'b0;
                    ioaddr = ADDR_DB_LO;
                    wdata  = DIV_TBL[br_cfg][7:0];
                end
                CFG_HI: begin
                    iocs   = 1'b1;
                    iorw   = 1'b0;
                    ioaddr = ADDR_DB_HI;
                    wdata  = DIV_TBL[cfg_q][15:8];
                end
                RX_RD: iocs = 1'b1;
                TX_WR: begin
                    iocs  = 1'b1;
                    iorw  = 1'b0;
                    wdata = fifo_rdata;
                end
                default: ;
            endcase
        end
    end

    assign databus   = (iocs & ~iorw) ? wdata : 8'bzzzz_zzzz;
    assign cfg_done  = cfg_done_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_spart_echo_driver.sv
// Bench for spart_echo_driver: a SPART-side stimulus process plus a
// transaction-level model of the expected bus activity, checked every cycle.
module tb_spart_echo_driver;
    import spart_pkg::*;

    localparam int K_NONE = 0, K_RD = 1, K_WR = 2, K_LO = 3, K_HI = 4, K_BAD = 5;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [1:0] br_cfg = 2'b00;
    logic       rda = 1'b0;
    logic       tbr = 1'b0;
    logic [7:0] rx_data = 8'h00;
    wire        iocs, iorw, cfg_done;
    wire  [1:0] ioaddr;
    wire  [7:0] databus;
    wire  [3:0] fifo_count;
    state_t     dbg_state;
    wire        tb_drive;

    assign tb_drive = iocs & iorw & (ioaddr == 2'b00);
    assign databus  = tb_drive ? rx_data : 8'bzzzz_zzzz;

    spart_echo_driver #(
        .CLK_FREQ_HZ (50_000_000),
        .FIFO_DEPTH  (8)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .br_cfg     (br_cfg),
        .rda        (rda),
        .tbr        (tbr),
        .iocs       (iocs),
        .iorw       (iorw),
        .ioaddr     (ioaddr),
        .databus    (databus),
        .cfg_done   (cfg_done),
        .fifo_count (fifo_count),
        .dbg_state  (dbg_state)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    task automatic chk(input string name, input int act, input int req);
        n_tests++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: actual=0x%0h required=0x%0h", name, cyc, act, req);
        end
    endtask

    function automatic logic [15:0] exp_div(input logic [1:0] sel);
        int baud;
        baud = 9600 * (1 << sel);
        return 16'(50_000_000 / baud);
    endfunction

    // ---------------- reference model + compare process ----------------
    logic [7:0] exp_q [$];
    int         exp_k;
    int         m_wait;
    logic       m_last_rx, m_done, m_cfg_pend, prev_done;
    logic [1:0] m_sel;
    int         rd_events = 0;
    int         done_cyc, done_falls = 0;
    int         log_k [$];
    int         log_c [$];
    logic [7:0] log_d [$];

    always @(negedge clk) begin : compare
        int          act_k;
        int          nxt;
        logic [15:0] dv;
        logic        rx_ok, tx_ok;
        logic [7:0]  dmy;
        if (!rst) begin
            exp_k      = K_LO;
            exp_q.delete();
            m_wait     = 0;
            m_last_rx  = 1'b0;
            m_done     = 1'b0;
            m_cfg_pend = 1'b0;
            prev_done  = 1'b0;
            cyc        = 0;
            done_cyc   = -1;
            log_k.delete();
            log_c.delete();
            log_d.delete();
        end else begin
            if (!iocs)                act_k = K_NONE;
            else if (iorw)            act_k = (ioaddr == 2'b00) ? K_RD : K_BAD;
            else if (ioaddr == 2'b00) act_k = K_WR;
            else if (ioaddr == 2'b10) act_k = K_LO;
            else if (ioaddr == 2'b11) act_k = K_HI;
            else                      act_k = K_BAD;
            chk("access_kind", act_k, exp_k);
            if (act_k == exp_k) begin
                if (exp_k == K_LO) begin
                    dv = exp_div(br_cfg);
                    chk("db_lo_data", int'(databus), int'(dv[7:0]));
                end else if (exp_k == K_HI) begin
                    dv = exp_div(m_sel);
                    chk("db_hi_data", int'(databus), int'(dv[15:8]));
                end else if (exp_k == K_WR && exp_q.size() > 0) begin
                    chk("echo_data", int'(databus), int'(exp_q[0]));
                end
            end
            chk("cfg_done", int'(cfg_done), int'(m_done));
            chk("fifo_count", int'(fifo_count), exp_q.size());
            if (iocs) begin
                log_k.push_back(act_k);
                log_c.push_back(cyc);
                log_d.push_back(databus);
            end
            if (cfg_done && done_cyc < 0) done_cyc = cyc;
            if (prev_done && !cfg_done) done_falls++;
            prev_done = cfg_done;

            // Advance the model: every access is followed by one quiet cycle,
            // then the driver decides from the current rda/tbr.
            nxt = K_NONE;
            case (exp_k)
                K_LO: begin
                    m_sel = br_cfg;
                    nxt   = K_HI;
                end
                K_HI: begin
                    m_wait     = 1;
                    m_cfg_pend = 1'b1;
                end
                K_RD: begin
                    exp_q.push_back(rx_data);
                    m_last_rx = 1'b1;
                    rd_events++;
                    m_wait = 1;
                end
                K_WR: begin
                    if (exp_q.size() > 0) dmy = exp_q.pop_front();
                    m_last_rx = 1'b0;
                    m_wait = 1;
                end
                default: begin
                    if (m_wait > 0) begin
                        m_wait--;
                        if (m_cfg_pend) begin
                            m_done     = 1'b1;
                            m_cfg_pend = 1'b0;
                        end
                    end else if (br_cfg != m_sel) begin
                        m_done = 1'b0;
                        nxt    = K_LO;
                    end else begin
                        rx_ok = rda && (exp_q.size() < 8);
                        tx_ok = tbr && (exp_q.size() > 0);
                        if (rx_ok && tx_ok) nxt = m_last_rx ? K_WR : K_RD;
                        else if (rx_ok)     nxt = K_RD;
                        else if (tx_ok)     nxt = K_WR;
                    end
                end
            endcase
            exp_k = nxt;
            cyc++;
        end
    end

    // ---------------- SPART-side stimulus ----------------
    logic [7:0] src [$];
    int         popped = 0;
    logic       rnd_mode = 1'b0;
    logic       tbr_set = 1'b0;

    task automatic tick();
        logic [7:0] dmy;
        @(posedge clk);
        #1;
        while (popped < rd_events) begin
            if (src.size() > 0) dmy = src.pop_front();
            popped++;
        end
        rx_data = (src.size() > 0) ? src[0] : 8'h00;
        rda     = (src.size() > 0) && (!rnd_mode || ($urandom_range(0, 3) != 0));
        tbr     = rnd_mode ? ($urandom_range(0, 2) != 0) : tbr_set;
    endtask

    task automatic do_reset(input logic [1:0] sel);
        rst     = 1'b0;
        br_cfg  = sel;
        tbr_set = 1'b0;
        src.delete();
        popped  = rd_events;
        repeat (3) tick();
        chk("rst_iocs", int'(iocs), 0);
        chk("rst_iorw", int'(iorw), 1);
        chk("rst_ioaddr", int'(ioaddr), 0);
        chk("rst_cfg_done", int'(cfg_done), 0);
        chk("rst_fifo_count", int'(fifo_count), 0);
        tick();
        rst = 1'b1;
    endtask

    function automatic int lk(input int i);
        return (i < log_k.size()) ? log_k[i] : -1;
    endfunction
    function automatic int lc(input int i);
        return (i < log_c.size()) ? log_c[i] : -1;
    endfunction
    function automatic int ld(input int i);
        return (i < log_d.size()) ? int'(log_d[i]) : -1;
    endfunction

    initial begin : stim
        int         base, falls0, same, found;
        logic [7:0] b9 [$];
        logic [7:0] wq [$];

        // Power-up divisor for 9600 baud.
        do_reset(2'b00);
        repeat (6) tick();
        chk("lo_kind_9600", lk(0), K_LO);
        chk("lo_cycle", lc(0), 0);
        chk("lo_data_9600", ld(0), 8'h58);
        chk("hi_kind_9600", lk(1), K_HI);
        chk("hi_data_9600", ld(1), 8'h14);
        chk("cfg_done_cycle", done_cyc, 3);

        // 76800 baud, then reconfigure to 19200 while idle.
        do_reset(2'b11);
        repeat (6) tick();
        chk("lo_data_76800", ld(0), 8'h8B);
        chk("hi_data_76800", ld(1), 8'h02);
        base   = log_k.size();
        falls0 = done_falls;
        br_cfg = 2'b01;
        repeat (8) tick();
        chk("recfg_lo_kind", lk(base), K_LO);
        chk("recfg_lo_data", ld(base), 8'h2C);
        chk("recfg_hi_kind", lk(base + 1), K_HI);
        chk("recfg_hi_data", ld(base + 1), 8'h0A);
        chk("recfg_done_drop", done_falls - falls0, 1);
        chk("recfg_done_back", int'(cfg_done), 1);

        // Single byte echo latency.
        tbr_set = 1'b1;
        repeat (2) tick();
        base = log_k.size();
        src.push_back(8'h6D);
        repeat (10) tick();
        chk("echo_rd_kind", lk(base), K_RD);
        chk("echo_rd_data", ld(base), 8'h6D);
        chk("echo_wr_kind", lk(base + 1), K_WR);
        chk("echo_wr_data", ld(base + 1), 8'h6D);
        chk("echo_latency", lc(base + 1) - lc(base), 3);

        // Fill with tbr low: ninth byte must stay in the SPART.
        tbr_set = 1'b0;
        tick();
        base = log_k.size();
        for (int i = 0; i < 9; i++) begin
            b9.push_back(8'($urandom_range(0, 255)));
            src.push_back(b9[i]);
        end
        repeat (40) tick();
        chk("full_count", int'(fifo_count), 8);
        chk("ninth_unread", src.size(), 1);
        chk("ninth_rda_high", int'(rda), 1);
        tbr_set = 1'b1;
        repeat (80) tick();
        for (int i = base; i < log_k.size(); i++) begin
            if (log_k[i] == K_WR) wq.push_back(log_d[i]);
        end
        chk("drain_writes", wq.size(), 9);
        for (int i = 0; i < 9; i++) begin
            chk("drain_order", (i < wq.size()) ? int'(wq[i]) : -1, int'(b9[i]));
        end

        // Both sides continuously ready with a non-empty FIFO: strict alternation.
        tbr_set = 1'b0;
        for (int i = 0; i < 3; i++) src.push_back(8'($urandom_range(0, 255)));
        repeat (20) tick();
        base = log_k.size();
        for (int i = 0; i < 12; i++) src.push_back(8'($urandom_range(0, 255)));
        tbr_set = 1'b1;
        repeat (50) tick();
        same = 0;
        for (int i = base; i < base + 11; i++) begin
            if (lk(i) == lk(i + 1) || lk(i + 1) < 0) same++;
        end
        chk("alternate", same, 0);
        repeat (40) tick();

        // Randomised traffic with occasional baud changes.
        rnd_mode = 1'b1;
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 3) == 0 && src.size() < 20) src.push_back(8'($urandom_range(0, 255)));
            if ($urandom_range(0, 299) == 0) br_cfg = 2'($urandom_range(0, 3));
            tick();
        end
        rnd_mode = 1'b0;
        tbr_set  = 1'b1;
        repeat (200) tick();

        // Reset arriving in the middle of a transmit write.
        br_cfg  = 2'b00;
        tbr_set = 1'b0;
        repeat (10) tick();
        src.push_back(8'hA5);
        src.push_back(8'h3C);
        repeat (20) tick();
        tbr_set = 1'b1;
        found = 0;
        for (int i = 0; i < 50 && found == 0; i++) begin
            tick();
            if (iocs && !iorw && ioaddr == 2'b00) found = 1;
        end
        chk("tx_before_reset", found, 1);
        #2;
        rst = 1'b0;
        #1;
        chk("midrst_iocs", int'(iocs), 0);
        chk("midrst_iorw", int'(iorw), 1);
        chk("midrst_fifo_count", int'(fifo_count), 0);
        chk("midrst_cfg_done", int'(cfg_done), 0);
        src.delete();
        popped = rd_events;
        repeat (2) tick();
        rst = 1'b1;
        repeat (6) tick();
        chk("restart_lo_kind", lk(0), K_LO);
        chk("restart_lo_cycle", lc(0), 0);
        chk("restart_lo_data", ld(0), 8'h58);
        chk("restart_hi_data", ld(1), 8'h14);

        repeat (5) tick();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
